// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states, frame
// configuration encodings and oversampling tick positions.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  typedef enum logic [1:0] {
    DW_5 = 2'b00,
    DW_6 = 2'b01,
    DW_7 = 2'b10,
    DW_8 = 2'b11
  } data_width_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_t;

  localparam logic [3:0] OVS_MID  = 4'd7;
  localparam logic [3:0] OVS_LAST = 4'd15;

  // Index of the final data bit: 5..8 bits map to 4..7.
  function automatic logic [2:0] last_bit_idx(data_width_t w);
    return {1'b1, w};
  endfunction

  function automatic logic parity_enabled(parity_mode_t m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser bringing an asynchronous single-bit input into the
// clk_i domain; the chain resets to RESET_VAL.
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // NOTE: resetting to the line's idle level keeps reset release from looking like a start bit.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_sync <= {STAGES{RESET_VAL}};
    else          r_sync <= {r_sync[STAGES-2:0], d_i};
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x-oversampled frame deserialiser with a valid/ack holding
// register carrying parity, framing and overrun status.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic       stop_bits_i,
  input  logic       data_ack_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       rx_idle_o
);

  logic w_rx_s;

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rx_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (w_rx_s)
  );

  rx_state_t    r_state;
  logic [3:0]   r_tick_cnt;
  logic [2:0]   r_bit_cnt;
  logic [7:0]   r_shift;
  data_width_t  r_width;
  parity_mode_t r_par_mode;
  logic         r_two_stop;
  logic         r_stop_idx;
  logic         r_armed;
  logic         r_par_err;
  logic         r_frm_err;
  logic         r_done;
  logic         r_idle;

  logic [7:0] w_shift_next;
  logic [2:0] w_align;

  assign w_shift_next = {w_rx_s, r_shift[7:1]};
  assign w_align      = 3'd3 - {1'b0, r_width};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_width    <= DW_8;
      r_par_mode <= PAR_NONE;
      r_two_stop <= 1'b0;
      r_stop_idx <= 1'b0;
      r_armed    <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_done     <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      // NOTE: default first, so the completion strobe is a single-cycle pulse.
      r_done <= 1'b0;
      if (ov_baud_rt_i) begin
        case (r_state)
          IDLE: begin
            // A frame may only begin after the line has been seen high (break recovery).
            if (w_rx_s) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_width    <= data_width_t'(data_width_i);
              r_par_mode <= parity_mode_t'(parity_mode_i);
              r_two_stop <= stop_bits_i;
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_shift    <= '0;
              r_stop_idx <= 1'b0;
              r_par_err  <= 1'b0;
              r_frm_err  <= 1'b0;
              r_state    <= START;
              r_idle     <= 1'b0;
            end
          end
          START: begin
            if (r_tick_cnt == OVS_MID) begin
              r_tick_cnt <= '0;
              if (w_rx_s) begin
                r_state <= IDLE;
                r_idle  <= 1'b1;
              end else begin
                r_state <= DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          DATA: begin
            if (r_tick_cnt == OVS_LAST) begin
              r_tick_cnt <= '0;
              if (r_bit_cnt == last_bit_idx(r_width)) begin
                r_shift   <= w_shift_next >> w_align;
                r_bit_cnt <= '0;
                r_state   <= parity_enabled(r_par_mode) ? PARITY : STOP;
              end else begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          PARITY: begin
            if (r_tick_cnt == OVS_LAST) begin
              r_tick_cnt <= '0;
              r_par_err  <= (r_par_mode == PAR_ODD) ? ~(w_rx_s ^ (^r_shift))
                                                    :  (w_rx_s ^ (^r_shift));
              r_state    <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          STOP: begin
            if (r_tick_cnt == OVS_LAST) begin
              r_tick_cnt <= '0;
              if (!w_rx_s) r_frm_err <= 1'b1;
              if (r_two_stop && !r_stop_idx) begin
                r_stop_idx <= 1'b1;
              end else begin
                r_state <= IDLE;
                r_idle  <= 1'b1;
                r_armed <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_idle  <= 1'b1;
          end
        endcase
      end
    end
  end

  logic [7:0] r_data;
  logic       r_valid;
  logic       r_out_par_err;
  logic       r_out_frm_err;
  logic       r_overrun;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_out_par_err <= 1'b0;
      r_out_frm_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (r_done && (!r_valid || data_ack_i)) begin
      r_data        <= r_shift;
      r_out_par_err <= r_par_err;
      r_out_frm_err <= r_frm_err;
      r_valid       <= 1'b1;
      r_overrun     <= 1'b0;
    end else if (r_done) begin
      r_overrun <= 1'b1;
    end else if (data_ack_i && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data_o        = r_data;
  assign data_valid_o  = r_valid;
  assign parity_err_o  = r_out_par_err;
  assign frame_err_o   = r_out_frm_err;
  assign overrun_err_o = r_overrun;
  assign rx_idle_o     = r_idle;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames are serialised bit by bit and
// expected bytes/flags are queued and compared when the receiver presents them.
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_res_t;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       ov_baud_rt_i;
  logic       rx_i;
  logic [1:0] data_width_i;
  logic [1:0] parity_mode_i;
  logic       stop_bits_i;
  logic       data_ack_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_err_o;
  logic       rx_idle_o;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      tick_phase;
  rx_res_t sb_q[$];

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .ov_baud_rt_i  (ov_baud_rt_i),
    .rx_i          (rx_i),
    .data_width_i  (data_width_i),
    .parity_mode_i (parity_mode_i),
    .stop_bits_i   (stop_bits_i),
    .data_ack_i    (data_ack_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .overrun_err_o (overrun_err_o),
    .rx_idle_o     (rx_idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Oversampling tick on every 4th clock, updated just after the rising edge.
  initial begin
    ov_baud_rt_i = 1'b0;
    tick_phase   = 0;
    forever begin
      @(posedge clk_i);
      #1;
      tick_phase   = (tick_phase + 1) % 4;
      ov_baud_rt_i = (tick_phase == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic set_cfg(input int nbits, input int pmode, input int nstop);
    data_width_i  = 2'(nbits - 5);
    parity_mode_i = 2'(pmode);
    stop_bits_i   = (nstop == 2);
  endtask

  // Called at a falling edge; drives one whole frame on rx_i and returns at a falling edge.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int pmode,
                            input bit par_flip, input int nstop, input bit stop2_zero,
                            input bit scramble);
    logic [7:0] m;
    logic       par;
    logic [1:0] sv_w;
    logic [1:0] sv_p;
    logic       sv_s;
    m = 8'h00;
    for (int i = 0; i < nbits; i++) m[i] = d[i];
    par = (pmode == 2) ? ~(^m) : (^m);
    par = par ^ par_flip;
    sv_w = data_width_i;
    sv_p = parity_mode_i;
    sv_s = stop_bits_i;
    rx_i = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_i);
    if (scramble) begin
      data_width_i  = ~data_width_i;
      parity_mode_i = ~parity_mode_i;
      stop_bits_i   = ~stop_bits_i;
    end
    for (int i = 0; i < nbits; i++) begin
      rx_i = d[i];
      repeat (BIT_CLKS) @(negedge clk_i);
    end
    if (pmode == 1 || pmode == 2) begin
      rx_i = par;
      repeat (BIT_CLKS) @(negedge clk_i);
    end
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_i);
    if (nstop == 2) begin
      rx_i = ~stop2_zero;
      repeat (BIT_CLKS) @(negedge clk_i);
      rx_i = 1'b1;
    end
    data_width_i  = sv_w;
    parity_mode_i = sv_p;
    stop_bits_i   = sv_s;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (data_valid_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic pulse_ack();
    data_ack_i = 1'b1;
    @(negedge clk_i);
    data_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i    = 1'b0;
    rx_i       = 1'b1;
    data_ack_i = 1'b0;
    set_cfg(8, 0, 1);
    repeat (4) @(negedge clk_i);
    n_checks++;
    if ({data_o, data_valid_o, parity_err_o, frame_err_o, overrun_err_o, rx_idle_o} !== 13'h001) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h required=001",
               {data_o, data_valid_o, parity_err_o, frame_err_o, overrun_err_o, rx_idle_o});
    end
    rst_n_i = 1'b1;
    repeat (40) @(negedge clk_i);
    n_checks++;
    if ({data_o, data_valid_o, parity_err_o, frame_err_o, overrun_err_o, rx_idle_o} !== 13'h001) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%h required=001",
               {data_o, data_valid_o, parity_err_o, frame_err_o, overrun_err_o, rx_idle_o});
    end
  endtask

  // 8N1 0xA5 with an independent timing model of when data_valid_o must rise.
  task automatic test_8n1_latency();
    int      p0;
    int      k_d;
    int      exp_j;
    int      got_j;
    rx_res_t exp;
    rx_res_t obs;
    set_cfg(8, 0, 1);
    p0  = tick_phase;
    k_d = 3;
    while (((p0 + k_d - 1) % 4) != 0) k_d++;
    exp_j = k_d + 4 * (8 + 16 * 9) + 1;
    got_j = -1;
    sb_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
    fork
      send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b0, 1'b0);
      begin
        for (int j = 1; j < 2000; j++) begin
          @(negedge clk_i);
          if (data_valid_o) begin
            got_j = j;
            break;
          end
        end
      end
    join
    n_checks++;
    if (got_j !== exp_j) begin
      n_fail++;
      $display("FAIL latency_8n1: valid after %0d clks required %0d", got_j, exp_j);
    end
    exp = sb_q.pop_front();
    obs = '{data: data_o, perr: parity_err_o, ferr: frame_err_o};
    n_checks++;
    if (obs !== exp || overrun_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_8n1: data=%h perr=%b ferr=%b ovr=%b required data=%h perr=%b ferr=%b ovr=0",
               obs.data, obs.perr, obs.ferr, overrun_err_o, exp.data, exp.perr, exp.ferr);
    end
    pulse_ack();
    n_checks++;
    if (data_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_8n1: valid=%b required 0", data_valid_o);
    end
  endtask

  // 7E1: good parity, then bad parity while the config inputs are scrambled mid-frame.
  task automatic test_parity_even();
    bit      got;
    rx_res_t exp;
    rx_res_t obs;
    set_cfg(7, 1, 1);
    for (int f = 0; f < 2; f++) begin
      sb_q.push_back('{data: 8'h35, perr: (f == 1), ferr: 1'b0});
      send_frame(8'h35, 7, 1, (f == 1), 1, 1'b0, (f == 1));
      wait_valid(200, got);
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL parity_valid_%0d: valid=0 required 1", f);
      end
      exp = sb_q.pop_front();
      obs = '{data: data_o, perr: parity_err_o, ferr: frame_err_o};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL parity_frame_%0d: data=%h perr=%b ferr=%b required data=%h perr=%b ferr=%b",
                 f, obs.data, obs.perr, obs.ferr, exp.data, exp.perr, exp.ferr);
      end
      pulse_ack();
      n_checks++;
      if (data_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_ack_%0d: valid=%b required 0", f, data_valid_o);
      end
    end
  endtask

  // 5O2: clean frame, then second stop bit forced low.
  task automatic test_5o2_stop();
    bit      got;
    rx_res_t exp;
    rx_res_t obs;
    set_cfg(5, 2, 2);
    for (int f = 0; f < 2; f++) begin
      sb_q.push_back('{data: 8'h1F, perr: 1'b0, ferr: (f == 1)});
      send_frame(8'h1F, 5, 2, 1'b0, 2, (f == 1), 1'b0);
      wait_valid(200, got);
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL stop_valid_%0d: valid=0 required 1", f);
      end
      exp = sb_q.pop_front();
      obs = '{data: data_o, perr: parity_err_o, ferr: frame_err_o};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL stop_frame_%0d: data=%h perr=%b ferr=%b required data=%h perr=%b ferr=%b",
                 f, obs.data, obs.perr, obs.ferr, exp.data, exp.perr, exp.ferr);
      end
      pulse_ack();
    end
  endtask

  // Short low pulse must be rejected at mid-bit; the next real frame still lands.
  task automatic test_glitch();
    bit      seen;
    bit      got;
    rx_res_t exp;
    rx_res_t obs;
    set_cfg(8, 0, 1);
    rx_i = 1'b0;
    repeat (20) @(negedge clk_i);
    rx_i = 1'b1;
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk_i);
      if (data_valid_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || rx_idle_o !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_reject: seen_valid=%b idle=%b required 0 1", seen, rx_idle_o);
    end
    sb_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    wait_valid(200, got);
    exp = sb_q.pop_front();
    obs = '{data: data_o, perr: parity_err_o, ferr: frame_err_o};
    n_checks++;
    if (!got || obs !== exp) begin
      n_fail++;
      $display("FAIL glitch_next: got=%b data=%h perr=%b ferr=%b required data=%h perr=%b ferr=%b",
               got, obs.data, obs.perr, obs.ferr, exp.data, exp.perr, exp.ferr);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    bit      got;
    rx_res_t exp;
    rx_res_t obs;
    set_cfg(8, 0, 1);
    sb_q.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h11, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    send_frame(8'h22, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    wait_valid(200, got);
    exp = sb_q.pop_front();
    obs = '{data: data_o, perr: parity_err_o, ferr: frame_err_o};
    n_checks++;
    if (!got || obs !== exp) begin
      n_fail++;
      $display("FAIL overrun_data: got=%b data=%h required data=%h", got, obs.data, exp.data);
    end
    n_checks++;
    if (overrun_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: overrun=%b required 1", overrun_err_o);
    end
    pulse_ack();
    n_checks++;
    if (data_valid_o !== 1'b0 || overrun_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_ack: valid=%b overrun=%b required 0 0", data_valid_o, overrun_err_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit      got;
    rx_res_t exp;
    rx_res_t obs;
    set_cfg(8, 0, 1);
    sb_q.push_back('{data: 8'h77, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h77, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    wait_valid(200, got);
    exp = sb_q.pop_front();
    obs = '{data: data_o, perr: parity_err_o, ferr: frame_err_o};
    n_checks++;
    if (!got || obs !== exp) begin
      n_fail++;
      $display("FAIL pre_reset_data: got=%b data=%h required data=%h", got, obs.data, exp.data);
    end
    fork
      send_frame(8'h55, 8, 0, 1'b0, 1, 1'b0, 1'b0);
      begin
        repeat (3 * BIT_CLKS) @(negedge clk_i);
        n_checks++;
        if (rx_idle_o !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_frame_busy: idle=%b required 0", rx_idle_o);
        end
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({data_o, data_valid_o, parity_err_o, frame_err_o, overrun_err_o, rx_idle_o} !== 13'h001) begin
          n_fail++;
          $display("FAIL mid_frame_reset: outputs=%h required=001",
                   {data_o, data_valid_o, parity_err_o, frame_err_o, overrun_err_o, rx_idle_o});
        end
      end
    join
    rst_n_i = 1'b1;
    repeat (40) @(negedge clk_i);
    sb_q.push_back('{data: 8'h66, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h66, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    wait_valid(200, got);
    exp = sb_q.pop_front();
    obs = '{data: data_o, perr: parity_err_o, ferr: frame_err_o};
    n_checks++;
    if (!got || obs !== exp || overrun_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_frame: got=%b data=%h perr=%b ferr=%b ovr=%b required data=%h perr=%b ferr=%b ovr=0",
               got, obs.data, obs.perr, obs.ferr, overrun_err_o, exp.data, exp.perr, exp.ferr);
    end
    pulse_ack();
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_8n1_latency();
    test_parity_even();
    test_5o2_stop();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
